// File: rtl/fpu_issue_collect.sv
// ============================================================================
//  Module   : fpu_issue_collect
//  Brief    : Issue/collect shell around a fixed-latency FP add/sub unit with
//             credit-checked result FIFO. Optional sticky ov/un flags are
//             built when FPU_STICKY_FLAGS_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpu_issue_collect #(
    parameter int NUM_OP  = 1,
    parameter int FPU_LAT = 2,
    parameter int DEPTH   = 4,
    parameter int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_op_valid,
    output logic              o_op_ready,
    input  logic [NUM_OP-1:0] i_op_add_sub,
    input  logic [31:0]       i_op_a,
    input  logic [31:0]       i_op_b,
    output logic [NUM_OP-1:0] o_fpu_add_sub,
    output logic [31:0]       o_fpu_a,
    output logic [31:0]       o_fpu_b,
    input  logic [31:0]       i_fpu_s,
    input  logic              i_fpu_ov,
    input  logic              i_fpu_un,
    output logic              o_res_valid,
    input  logic              i_res_ready,
    output logic [31:0]       o_res_s,
    output logic              o_res_ov,
    output logic              o_res_un,
    output logic [CNT_W-1:0]  o_count
`ifdef FPU_STICKY_FLAGS_EN
    ,
    output logic              o_sticky_ov,
    output logic              o_sticky_un,
    input  logic              i_sticky_clr
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int EW = 34;

    logic              op_ready_q;
    logic [NUM_OP-1:0] fpu_add_sub_q;
    logic [31:0]       fpu_a_q;
    logic [31:0]       fpu_b_q;
    logic [FPU_LAT-1:0] vpipe_q;
    logic [FPU_LAT-1:0] vpipe_d;
    logic [PW-1:0]     wr_ptr_q;
    logic [PW-1:0]     rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic [EW-1:0]     mem_q [DEPTH];

    logic              w_fire;
    logic              w_pop;
    logic              w_push;
    logic              w_empty;
    logic              w_full;
    logic              w_ready_d;
    logic [EW-1:0]     w_head;

    assign w_fire  = i_op_valid & op_ready_q;
    assign w_empty = (wr_ptr_q == rd_ptr_q);
    assign w_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign w_pop   = ~w_empty & i_res_ready;
    assign w_push  = vpipe_q[FPU_LAT-1];

    // Credits cover both FIFO entries and ops still inside the FPU pipe.
    assign count_d   = count_q + CNT_W'(w_fire) - CNT_W'(w_pop);
    assign w_ready_d = (count_d < CNT_W'(DEPTH));

    generate
        if (FPU_LAT == 1) begin : g_lat1
            assign vpipe_d = w_fire;
        end else begin : g_latn
            assign vpipe_d = {vpipe_q[FPU_LAT-2:0], w_fire};
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            op_ready_q    <= 1'b0;
            fpu_add_sub_q <= '0;
            fpu_a_q       <= '0;
            fpu_b_q       <= '0;
            vpipe_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            op_ready_q <= w_ready_d;
            if (w_fire) begin
                fpu_add_sub_q <= i_op_add_sub;
                fpu_a_q       <= i_op_a;
                fpu_b_q       <= i_op_b;
            end
            vpipe_q <= vpipe_d;
            if (w_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (w_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
        end
    end

    // Storage needs no reset: entries are only read between valid pointers.
    always_ff @(posedge i_clk) begin
        if (w_push) mem_q[wr_ptr_q[AW-1:0]] <= {i_fpu_un, i_fpu_ov, i_fpu_s};
    end

    assign w_head = mem_q[rd_ptr_q[AW-1:0]];

    assign o_op_ready    = op_ready_q;
    assign o_fpu_add_sub = fpu_add_sub_q;
    assign o_fpu_a       = fpu_a_q;
    assign o_fpu_b       = fpu_b_q;
    assign o_res_valid   = ~w_empty;
    assign o_res_s       = w_empty ? 32'h0 : w_head[31:0];
    assign o_res_ov      = ~w_empty & w_head[32];
    assign o_res_un      = ~w_empty & w_head[33];
    assign o_count       = count_q;

`ifdef FPU_STICKY_FLAGS_EN
    logic sticky_ov_q;
    logic sticky_un_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sticky_ov_q <= 1'b0;
            sticky_un_q <= 1'b0;
        end else begin
            sticky_ov_q <= (sticky_ov_q & ~i_sticky_clr) | (w_push & i_fpu_ov);
            sticky_un_q <= (sticky_un_q & ~i_sticky_clr) | (w_push & i_fpu_un);
        end
    end

    assign o_sticky_ov = sticky_ov_q;
    assign o_sticky_un = sticky_un_q;
`endif

    a_no_push_when_full: assert property (@(posedge i_clk) disable iff (i_rst)
        !(w_push && w_full));

endmodule

`default_nettype wire

// File: tb/tb_fpu_issue_collect.sv
// ============================================================================
//  Module   : tb_fpu_issue_collect
//  Brief    : Self-checking bench for fpu_issue_collect with an FPU stand-in.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fpu_issue_collect;

    localparam int DEPTH = 4;
    localparam int CNT_W = 3;
    localparam int NVEC  = 6;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              op_valid = 1'b0;
    logic              o_op_ready;
    logic [0:0]        op_add_sub = 1'b0;
    logic [31:0]       op_a = '0;
    logic [31:0]       op_b = '0;
    logic [0:0]        o_fpu_add_sub;
    logic [31:0]       o_fpu_a;
    logic [31:0]       o_fpu_b;
    logic [31:0]       fpu_s = '0;
    logic              fpu_ov = 1'b0;
    logic              fpu_un = 1'b0;
    logic              o_res_valid;
    logic              res_ready = 1'b0;
    logic [31:0]       o_res_s;
    logic              o_res_ov;
    logic              o_res_un;
    logic [CNT_W-1:0]  o_count;
`ifdef FPU_STICKY_FLAGS_EN
    logic              o_sticky_ov;
    logic              o_sticky_un;
    logic              sticky_clr = 1'b0;
`endif

    always #5 clk = ~clk;

    fpu_issue_collect #(.NUM_OP(1), .FPU_LAT(2), .DEPTH(DEPTH)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_op_valid    (op_valid),
        .o_op_ready    (o_op_ready),
        .i_op_add_sub  (op_add_sub),
        .i_op_a        (op_a),
        .i_op_b        (op_b),
        .o_fpu_add_sub (o_fpu_add_sub),
        .o_fpu_a       (o_fpu_a),
        .o_fpu_b       (o_fpu_b),
        .i_fpu_s       (fpu_s),
        .i_fpu_ov      (fpu_ov),
        .i_fpu_un      (fpu_un),
        .o_res_valid   (o_res_valid),
        .i_res_ready   (res_ready),
        .o_res_s       (o_res_s),
        .o_res_ov      (o_res_ov),
        .o_res_un      (o_res_un),
        .o_count       (o_count)
`ifdef FPU_STICKY_FLAGS_EN
        ,
        .o_sticky_ov   (o_sticky_ov),
        .o_sticky_un   (o_sticky_un),
        .i_sticky_clr  (sticky_clr)
`endif
    );

    // op encoding: 0 = add, 1 = sub
    typedef struct {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] s;
        logic        ov;
        logic        un;
    } vec_t;

    vec_t        vt [NVEC];
    logic [33:0] sb [$];
    int          checks = 0;
    int          errors = 0;
    bit          chk_en = 1'b0;
    bit          last_fire = 1'b0;
    int          pops = 0;

    // Known IEEE results come from the table; other operands get a
    // deterministic tag so the scoreboard can track order and identity.
    function automatic logic [33:0] fmodel(logic op, logic [31:0] a, logic [31:0] b);
        for (int i = 0; i < NVEC; i++)
            if (vt[i].op == op && vt[i].a == a && vt[i].b == b)
                return {vt[i].un, vt[i].ov, vt[i].s};
        return {a[2] & b[9], a[7] ^ b[3], (a ^ {b[15:0], b[31:16]}) + {31'b0, op}};
    endfunction

    // FPU stand-in: one register stage behind the registered operand outputs.
    always @(posedge clk) {fpu_un, fpu_ov, fpu_s} <= fmodel(o_fpu_add_sub[0], o_fpu_a, o_fpu_b);

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        if (chk_en) begin
            check("count", 64'(o_count), 64'(sb.size()));
            check("op_ready", 64'(o_op_ready), 64'(sb.size() < DEPTH));
        end
        last_fire = op_valid && o_op_ready;
        if (last_fire) sb.push_back(fmodel(op_add_sub[0], op_a, op_b));
        if (o_res_valid && res_ready) begin
            pops++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result actual=%0h expected=none", o_res_s);
            end else begin
                check("result", {30'b0, o_res_un, o_res_ov, o_res_s}, {30'b0, sb.pop_front()});
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && sb.size() > 0; i++) step();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout actual=%0d expected=0 outstanding", sb.size());
        end
    endtask

    initial begin
        int drops;
        int idx;
        int stale;
        int fired;
        int cyc;

        vt[0] = '{1'b0, 32'h3F800000, 32'h40000000, 32'h40400000, 1'b0, 1'b0};
        vt[1] = '{1'b1, 32'h40400000, 32'h3F800000, 32'h40000000, 1'b0, 1'b0};
        vt[2] = '{1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 1'b1, 1'b0};
        vt[3] = '{1'b0, 32'h40200000, 32'h3F000000, 32'h40400000, 1'b0, 1'b0};
        vt[4] = '{1'b1, 32'h00C00000, 32'h00800000, 32'h00000000, 1'b0, 1'b1};
        vt[5] = '{1'b0, 32'hBF800000, 32'h3F800000, 32'h00000000, 1'b0, 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 64'(o_op_ready), 0);
        check("rst_valid", 64'(o_res_valid), 0);
        check("rst_count", 64'(o_count), 0);
        check("rst_fpu_a", 64'(o_fpu_a), 0);
        check("rst_res_s", 64'(o_res_s), 0);
        rst = 1'b0;
        step();
        check("ready_after_rst", 64'(o_op_ready), 1);
        chk_en = 1'b1;

        // Single op latency
        op_valid = 1'b1; op_add_sub = vt[0].op; op_a = vt[0].a; op_b = vt[0].b;
        step();
        op_valid = 1'b0;
        check("c1_fpu_a", 64'(o_fpu_a), 64'h3F800000);
        check("c1_fpu_b", 64'(o_fpu_b), 64'h40000000);
        check("c1_valid", 64'(o_res_valid), 0);
        step();
        check("c2_valid", 64'(o_res_valid), 0);
        step();
        check("c3_valid", 64'(o_res_valid), 1);
        check("c3_res_s", 64'(o_res_s), 64'h40400000);
        check("c3_flags", 64'({o_res_ov, o_res_un}), 0);
        step();
        check("c3_hold", 64'(o_res_s), 64'h40400000);
        res_ready = 1'b1;
        step();
        check("single_empty", 64'(o_res_valid), 0);

        // Table vectors back-to-back
        for (int i = 0; i < NVEC; i++) begin
            op_valid = 1'b1; op_add_sub = vt[i].op; op_a = vt[i].a; op_b = vt[i].b;
            step();
            check("table_fire", 64'(last_fire), 1);
        end
        op_valid = 1'b0;
        drain();
`ifdef FPU_STICKY_FLAGS_EN
        check("sticky_ov", 64'(o_sticky_ov), 1);
        check("sticky_un", 64'(o_sticky_un), 1);
        sticky_clr = 1'b1;
        step();
        sticky_clr = 1'b0;
        check("sticky_ov_clr", 64'(o_sticky_ov), 0);
        check("sticky_un_clr", 64'(o_sticky_un), 0);
`endif

        // Stream 8 ops, consumer always ready
        pops = 0; drops = 0;
        for (int k = 0; k < 8; k++) begin
            op_valid = 1'b1; op_add_sub = 1'(k); op_a = $urandom(); op_b = $urandom();
            step();
            if (!last_fire) drops++;
        end
        op_valid = 1'b0;
        repeat (3) step();
        check("stream_drops", 64'(drops), 0);
        check("stream_pops", 64'(pops), 8);

        // Backpressure: 6 ops offered, only DEPTH accepted
        res_ready = 1'b0; idx = 0;
        for (int k = 0; k < 8; k++) begin
            op_valid = (idx < 6); op_a = 32'h1000 + idx; op_b = 32'h2000 + idx; op_add_sub = 1'b0;
            step();
            if (last_fire) idx++;
        end
        check("bp_accepted", 64'(idx), 4);
        check("bp_ready", 64'(o_op_ready), 0);
        check("bp_count", 64'(o_count), 4);
        res_ready = 1'b1;
        for (int k = 0; k < 40 && (idx < 6 || sb.size() > 0); k++) begin
            op_valid = (idx < 6); op_a = 32'h1000 + idx; op_b = 32'h2000 + idx;
            step();
            if (last_fire) idx++;
        end
        op_valid = 1'b0;
        check("bp_resume", 64'(idx), 6);
        check("bp_drained", 64'(sb.size()), 0);

        // Reset with 1 in FIFO and 2 in flight
        res_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            op_valid = 1'b1; op_a = $urandom(); op_b = $urandom();
            step();
        end
        op_valid = 1'b0;
        check("mid_valid", 64'(o_res_valid), 1);
        check("mid_count", 64'(o_count), 3);
        rst = 1'b1;
        chk_en = 1'b0;
        step();
        rst = 1'b0;
        sb.delete();
        check("mid_rst_valid", 64'(o_res_valid), 0);
        check("mid_rst_count", 64'(o_count), 0);
        res_ready = 1'b1; stale = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (o_res_valid) stale++;
        end
        check("mid_rst_stale", 64'(stale), 0);
        chk_en = 1'b1;

        // Random valid/ready over 10k ops
        fired = 0; cyc = 0;
        while (fired < 10000 && cyc < 40000) begin
            op_valid   = ($urandom_range(0, 9) < 7);
            op_add_sub = 1'($urandom());
            op_a       = $urandom();
            op_b       = $urandom();
            res_ready  = ($urandom_range(0, 9) < 7);
            step();
            if (last_fire) fired++;
            cyc++;
        end
        op_valid = 1'b0;
        res_ready = 1'b1;
        check("rand_fired", 64'(fired), 10000);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
